// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan decoder: segment codes, FSM states,
// digit-slot indices and strobe helper functions.
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] WEI_NONE  = 4'hF;

    localparam logic [1:0] SLOT_UNITS = 2'd0;
    localparam logic [1:0] SLOT_TENS  = 2'd1;
    localparam logic [1:0] SLOT_HUND  = 2'd2;
    localparam logic [1:0] SLOT_THOU  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    function automatic logic one_low(input logic [3:0] wei);
        return (wei == 4'b1110) || (wei == 4'b1101) ||
               (wei == 4'b1011) || (wei == 4'b0111);
    endfunction

    function automatic logic [1:0] slot_idx(input logic [3:0] wei);
        logic [1:0] idx;
        case (wei)
            4'b1110: idx = SLOT_UNITS;
            4'b1101: idx = SLOT_TENS;
            4'b1011: idx = SLOT_HUND;
            4'b0111: idx = SLOT_THOU;
            default: idx = SLOT_UNITS;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational active-low 7-segment code {g..a} to BCD digit, with a flag
// that is low for any code that is not one of the ten digit glyphs.
module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] i_code,
    output logic       o_valid,
    output logic [3:0] o_digit
);

    // Glyph lookup; unknown codes report invalid with a zero digit.
    always_comb begin
        o_valid = 1'b1;
        o_digit = 4'd0;
        case (i_code)
            SEG_0:   o_digit = 4'd0;
            SEG_1:   o_digit = 4'd1;
            SEG_2:   o_digit = 4'd2;
            SEG_3:   o_digit = 4'd3;
            SEG_4:   o_digit = 4'd4;
            SEG_5:   o_digit = 4'd5;
            SEG_6:   o_digit = 4'd6;
            SEG_7:   o_digit = 4'd7;
            SEG_8:   o_digit = 4'd8;
            SEG_9:   o_digit = 4'd9;
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Loopback monitor for a multiplexed 7-seg scan bus: debounces strobes, decodes
// digits and assembles frames. Optional macro BLANK_LEAD_EN: blank tens = 0.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int         SETTLE_CYC = 4,
    parameter logic [3:0] USED_MASK  = 4'b0011,
    parameter int         TIMEOUT    = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sm_wei,
    input  logic [7:0] sm_duan,
    output logic [6:0] value,
    output logic       value_valid,
    output logic       value_chg,
    output logic       seg_err,
    output logic       wei_err,
    output logic       stale
);

    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);

    logic [3:0]    r_wei;
    logic [6:0]    r_seg;
    state_t        r_state, w_next_state;
    logic [3:0]    r_pat, w_pat_next, r_last, w_last_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [3:0]    r_slot [4];
    logic [3:0]    r_seen, w_seen_next;
    logic [TW-1:0] r_to, w_to_next;
    logic [6:0]    r_value, w_new_value;
    logic          r_valid, r_chg, r_seg_err, r_wei_err, r_stale;
    logic          w_code_ok, w_blank_tens, w_digit_ok, w_sample, w_one_low, w_capture, w_frame_done;
    logic [3:0]    w_digit, w_cap_digit, w_units, w_tens;
    logic [1:0]    w_idx;
    logic          w_unused_dp;

    // The decimal point carries no digit information.
    assign w_unused_dp = sm_duan[7];

    seg7_to_bcd u_dec (
        .i_code  (r_seg),
        .o_valid (w_code_ok),
        .o_digit (w_digit)
    );

    assign w_sample  = (r_state == SAMPLE);
    assign w_one_low = one_low(r_pat);
    assign w_idx     = slot_idx(r_pat);
    assign w_capture = w_sample & w_one_low;

`ifdef BLANK_LEAD_EN
    assign w_blank_tens = (w_idx == SLOT_TENS) && (r_seg == SEG_BLANK);
`else
    assign w_blank_tens = 1'b0;
`endif

    assign w_digit_ok  = w_code_ok | w_blank_tens;
    assign w_cap_digit = w_code_ok ? w_digit : (w_blank_tens ? 4'd0 : r_slot[w_idx]);

    // Input capture register; all debounce timing is counted from these copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wei <= WEI_NONE;
            r_seg <= SEG_BLANK;
        end else begin
            r_wei <= sm_wei;
            r_seg <= sm_duan[6:0];
        end
    end

    // FSM state, settle counter and pattern tracking registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pat   <= WEI_NONE;
            r_last  <= WEI_NONE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_pat   <= w_pat_next;
            r_last  <= w_last_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: a strobe pattern must be stable SETTLE_CYC cycles before one sample.
    always_comb begin
        w_next_state = r_state;
        w_pat_next   = r_pat;
        w_last_next  = r_last;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if ((r_wei != r_last) && (r_wei != WEI_NONE)) begin
                    w_next_state = SETTLE;
                    w_pat_next   = r_wei;
                    w_cnt_next   = '0;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SETTLE, HOLD: begin
                if (r_wei != r_pat) begin
                    if (r_wei == WEI_NONE) begin
                        w_next_state = IDLE;
                    end else begin
                        w_next_state = SETTLE;
                        w_pat_next   = r_wei;
                        w_cnt_next   = '0;
                    end
                end else if (r_state == SETTLE) begin
                    if (r_cnt == CNT_LAST) begin
                        w_next_state = SAMPLE;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end else begin
                    w_next_state = HOLD;
                end
            end
            SAMPLE: begin
                w_next_state = HOLD;
                w_last_next  = r_pat;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Frame assembly sees the digit being captured this cycle so value follows SAMPLE by one cycle.
    always_comb begin
        w_seen_next = r_seen;
        w_units     = r_slot[0];
        w_tens      = r_slot[1];
        if (w_capture) begin
            w_seen_next[w_idx] = 1'b1;
            if (w_idx == SLOT_UNITS) begin
                w_units = w_cap_digit;
            end else if (w_idx == SLOT_TENS) begin
                w_tens = w_cap_digit;
            end else begin
                w_units = r_slot[0];
            end
        end else begin
            w_seen_next = r_seen;
        end
    end

    assign w_frame_done = w_capture && ((w_seen_next & USED_MASK) == USED_MASK);
    assign w_new_value  = USED_MASK[1] ? (({3'b000, w_tens} * 7'd10) + {3'b000, w_units})
                                       : {3'b000, w_units};
    assign w_to_next    = w_frame_done ? '0 : ((r_to == TO_MAX) ? r_to : r_to + 1'b1);

    // Slot storage, frame tracking, timeout and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_slot[i] <= 4'd0;
            r_seen    <= 4'd0;
            r_to      <= '0;
            r_value   <= 7'd0;
            r_valid   <= 1'b0;
            r_chg     <= 1'b0;
            r_seg_err <= 1'b0;
            r_wei_err <= 1'b0;
            r_stale   <= 1'b0;
        end else begin
            if (w_capture) r_slot[w_idx] <= w_cap_digit;
            r_seen    <= w_frame_done ? 4'd0 : w_seen_next;
            r_to      <= w_to_next;
            r_valid   <= w_frame_done;
            r_chg     <= w_frame_done && (w_new_value != r_value);
            if (w_frame_done) r_value <= w_new_value;
            r_seg_err <= r_seg_err | (w_capture & ~w_digit_ok);
            r_wei_err <= w_sample & ~w_one_low;
            r_stale   <= (w_to_next == TO_MAX);
        end
    end

    assign value       = r_value;
    assign value_valid = r_valid;
    assign value_chg   = r_chg;
    assign seg_err     = r_seg_err;
    assign wei_err     = r_wei_err;
    assign stale       = r_stale;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed self-checking bench for seg_scan_decoder (default parameters).
module tb_seg_scan_decoder;
    import seg_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] sm_wei = 4'hF;
    logic [7:0] sm_duan = 8'hFF;
    logic [6:0] value;
    logic       value_valid, value_chg, seg_err, wei_err, stale;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0, n_chg = 0, n_werr = 0;
    int cyc = 0, valid_cyc = 0;
    logic stale_at_valid = 1'b1;

    seg_scan_decoder dut (
        .clk(clk), .rst_n(rst_n), .sm_wei(sm_wei), .sm_duan(sm_duan),
        .value(value), .value_valid(value_valid), .value_chg(value_chg),
        .seg_err(seg_err), .wei_err(wei_err), .stale(stale)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (value_valid === 1'b1) begin
            n_valid        <= n_valid + 1;
            valid_cyc      <= cyc + 1;
            stale_at_valid <= stale;
        end
        if (value_chg === 1'b1) n_chg <= n_chg + 1;
        if (wei_err === 1'b1) n_werr <= n_werr + 1;
    end

    task automatic scan(input logic [3:0] w, input logic [6:0] c, input int n);
        sm_wei  = w;
        sm_duan = {1'b1, c};
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        n_cmp++; if (value !== 7'd0) begin $display("FAIL reset_value: got %0d expected 0", value); n_bad++; end
        n_cmp++; if (value_valid !== 1'b0) begin $display("FAIL reset_valid: got %b expected 0", value_valid); n_bad++; end
        n_cmp++; if (value_chg !== 1'b0) begin $display("FAIL reset_chg: got %b expected 0", value_chg); n_bad++; end
        n_cmp++; if (seg_err !== 1'b0) begin $display("FAIL reset_seg_err: got %b expected 0", seg_err); n_bad++; end
        n_cmp++; if (wei_err !== 1'b0) begin $display("FAIL reset_wei_err: got %b expected 0", wei_err); n_bad++; end
        n_cmp++; if (stale !== 1'b0) begin $display("FAIL reset_stale: got %b expected 0", stale); n_bad++; end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        scan(4'hF, SEG_BLANK, 4);
    endtask

    task automatic test_frame27;
        int v0, c0, t0;
        v0 = n_valid; c0 = n_chg;
        scan(4'b1110, SEG_7, 20);
        n_cmp++; if (n_valid != v0) begin $display("FAIL f27_no_early_valid: got %0d pulses expected 0", n_valid - v0); n_bad++; end
        t0 = cyc;
        scan(4'b1101, SEG_2, 20);
        n_cmp++; if (value !== 7'd27) begin $display("FAIL f27_value: got %0d expected 27", value); n_bad++; end
        n_cmp++; if (n_valid - v0 != 1) begin $display("FAIL f27_valid: got %0d pulses expected 1", n_valid - v0); n_bad++; end
        n_cmp++; if (n_chg - c0 != 1) begin $display("FAIL f27_chg: got %0d pulses expected 1", n_chg - c0); n_bad++; end
        n_cmp++; if (valid_cyc - t0 != 7) begin $display("FAIL f27_latency: got %0d cycles expected 7", valid_cyc - t0); n_bad++; end
    endtask

    task automatic test_repeat;
        int v0, c0;
        v0 = n_valid; c0 = n_chg;
        scan(4'b1110, SEG_7, 20);
        scan(4'b1101, SEG_2, 20);
        n_cmp++; if (value !== 7'd27) begin $display("FAIL rep_value: got %0d expected 27", value); n_bad++; end
        n_cmp++; if (n_valid - v0 != 1) begin $display("FAIL rep_valid: got %0d pulses expected 1", n_valid - v0); n_bad++; end
        n_cmp++; if (n_chg - c0 != 0) begin $display("FAIL rep_chg: got %0d pulses expected 0", n_chg - c0); n_bad++; end
        n_cmp++; if (seg_err !== 1'b0) begin $display("FAIL rep_seg_err: got %b expected 0", seg_err); n_bad++; end
    endtask

    task automatic test_glitch;
        int v0;
        v0 = n_valid;
        scan(4'b1110, SEG_9, 2);
        scan(4'b1101, SEG_3, 20);
        n_cmp++; if (n_valid != v0) begin $display("FAIL glitch_captured: got %0d pulses expected 0", n_valid - v0); n_bad++; end
        scan(4'b1110, SEG_4, 20);
        n_cmp++; if (value !== 7'd34) begin $display("FAIL glitch_value: got %0d expected 34", value); n_bad++; end
        n_cmp++; if (n_valid - v0 != 1) begin $display("FAIL glitch_valid: got %0d pulses expected 1", n_valid - v0); n_bad++; end
    endtask

    task automatic test_wei_err;
        int v0, w0;
        v0 = n_valid; w0 = n_werr;
        scan(4'b1100, SEG_8, 10);
        scan(4'hF, SEG_BLANK, 5);
        n_cmp++; if (n_werr - w0 != 1) begin $display("FAIL wei_err_pulses: got %0d expected 1", n_werr - w0); n_bad++; end
        n_cmp++; if (n_valid != v0) begin $display("FAIL wei_err_valid: got %0d pulses expected 0", n_valid - v0); n_bad++; end
        n_cmp++; if (value !== 7'd34) begin $display("FAIL wei_err_value: got %0d expected 34", value); n_bad++; end
    endtask

    task automatic test_blank;
        logic [6:0] exp_v;
        logic       exp_e;
`ifdef BLANK_LEAD_EN
        exp_v = 7'd5;  exp_e = 1'b0;
`else
        exp_v = 7'd35; exp_e = 1'b1;
`endif
        scan(4'b1110, SEG_5, 20);
        scan(4'b1101, SEG_BLANK, 20);
        n_cmp++; if (value !== exp_v) begin $display("FAIL blank_value: got %0d expected %0d", value, exp_v); n_bad++; end
        n_cmp++; if (seg_err !== exp_e) begin $display("FAIL blank_seg_err: got %b expected %b", seg_err, exp_e); n_bad++; end
        scan(4'b1110, SEG_7, 20);
        scan(4'b1101, SEG_2, 20);
        n_cmp++; if (value !== 7'd27) begin $display("FAIL sticky_value: got %0d expected 27", value); n_bad++; end
        n_cmp++; if (seg_err !== exp_e) begin $display("FAIL sticky_seg_err: got %b expected %b", seg_err, exp_e); n_bad++; end
    endtask

    task automatic test_stale;
        int v0;
        scan(4'hF, SEG_BLANK, 1000);
        n_cmp++; if (stale !== 1'b0) begin $display("FAIL stale_early: got %b expected 0", stale); n_bad++; end
        scan(4'hF, SEG_BLANK, 49020);
        n_cmp++; if (stale !== 1'b1) begin $display("FAIL stale_set: got %b expected 1", stale); n_bad++; end
        v0 = n_valid;
        scan(4'b1110, SEG_1, 20);
        n_cmp++; if (stale !== 1'b1) begin $display("FAIL stale_partial: got %b expected 1", stale); n_bad++; end
        scan(4'b1101, SEG_9, 20);
        n_cmp++; if (n_valid - v0 != 1) begin $display("FAIL stale_frame_valid: got %0d pulses expected 1", n_valid - v0); n_bad++; end
        n_cmp++; if (stale_at_valid !== 1'b0) begin $display("FAIL stale_clear_at_valid: got %b expected 0", stale_at_valid); n_bad++; end
        n_cmp++; if (value !== 7'd91) begin $display("FAIL stale_value: got %0d expected 91", value); n_bad++; end
    endtask

    task automatic test_reset_midframe;
        int v0;
        scan(4'b1110, SEG_8, 20);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (value !== 7'd0) begin $display("FAIL rst_mid_value: got %0d expected 0", value); n_bad++; end
        n_cmp++; if (seg_err !== 1'b0) begin $display("FAIL rst_mid_seg_err: got %b expected 0", seg_err); n_bad++; end
        n_cmp++; if (stale !== 1'b0 || value_valid !== 1'b0 || value_chg !== 1'b0 || wei_err !== 1'b0) begin
            $display("FAIL rst_mid_flags: got %b%b%b%b expected 0000", stale, value_valid, value_chg, wei_err); n_bad++;
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        v0 = n_valid;
        scan(4'b1101, SEG_1, 20);
        n_cmp++; if (n_valid != v0) begin $display("FAIL rst_mid_partial_kept: got %0d pulses expected 0", n_valid - v0); n_bad++; end
        scan(4'b1110, SEG_6, 20);
        n_cmp++; if (value !== 7'd16) begin $display("FAIL rst_mid_value_after: got %0d expected 16", value); n_bad++; end
    endtask

    initial begin
        test_reset();
        test_frame27();
        test_repeat();
        test_glitch();
        test_wei_err();
        test_blank();
        test_stale();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
